// File: rtl/hack_pkg.sv
// Shared types and defaults for the Hack program loader.
// The byte stream carries big-endian 16-bit words and a 16-bit length header.
package hack_pkg;

    localparam int unsigned ADDR_W_DEF    = 15;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned MAX_WORDS_DEF = 32768;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_RUN,
        ST_ERROR
    } state_t;

    // One instruction word as it arrives on the byte stream.
    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } word_t;

endpackage

// File: rtl/hack_loader_if.sv
// Byte-stream input and instruction-ROM write bus of the loader.
// master = byte source / ROM side, slave = loader.
interface hack_loader_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_wdata;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  rom_we,
        input  rom_addr,
        input  rom_wdata
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output rom_we,
        output rom_addr,
        output rom_wdata
    );
endinterface

// File: rtl/hack_loader.sv
// Loads a length-prefixed big-endian word stream into the instruction ROM
// and holds the CPU in reset until a complete program is present.
module hack_loader
    import hack_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    hack_loader_if.slave bus,
    input  logic         load_req,
    output logic         cpu_reset,
    output logic         busy,
    output logic         error
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    word_t               word_q, word_d;
    logic [BYTE_W-1:0]   len_hi_q, len_hi_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;

    logic                hs;
    logic [CNT_W-1:0]    len;

    assign hs  = bus.rx_valid && ready_q;
    assign len = {len_hi_q, bus.rx_data};

    // Next state, datapath updates and registered-output decode of the next state.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        word_d   = word_q;
        len_hi_d = len_hi_q;
        count_d  = count_q;

        case (state_q)
            ST_LEN_HI: begin
                if (hs) begin
                    len_hi_d = bus.rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (hs) begin
                    if (len == '0) begin
                        state_d = ST_RUN;
                    end else if (32'(len) > 32'(MAX_WORDS)) begin
                        state_d = ST_ERROR;
                    end else begin
                        count_d = len;
                        addr_d  = '0;
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (hs) begin
                    word_d.hi = bus.rx_data;
                    state_d   = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (hs) begin
                    word_d.lo = bus.rx_data;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Address wraps naturally after the last word of a full-size image.
                addr_d  = ADDR_W'(addr_q + ADDR_W'(1));
                count_d = CNT_W'(count_q - CNT_W'(1));
                state_d = (count_q == CNT_W'(1)) ? ST_RUN : ST_DATA_HI;
            end
            ST_RUN, ST_ERROR: begin
                if (load_req) begin
                    state_d = ST_LEN_HI;
                end
            end
            default: begin
                state_d = ST_LEN_HI;
            end
        endcase

        ready_d     = (state_d == ST_LEN_HI)  || (state_d == ST_LEN_LO) ||
                      (state_d == ST_DATA_HI) || (state_d == ST_DATA_LO);
        we_d        = (state_d == ST_WRITE);
        cpu_reset_d = (state_d != ST_RUN);
        busy_d      = ready_d || we_d;
        error_d     = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_LEN_HI;
            addr_q      <= '0;
            word_q      <= '0;
            len_hi_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            len_hi_q    <= len_hi_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign bus.rx_ready  = ready_q;
    assign bus.rom_we    = we_q;
    assign bus.rom_addr  = addr_q;
    assign bus.rom_wdata = DATA_W'(word_q);
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign error         = error_q;

endmodule

// File: tb/tb_hack_loader.sv
// Directed bench for hack_loader: stream-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_hack_loader;
    import hack_pkg::*;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 16;
    localparam int unsigned MW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic load_req = 1'b0;
    logic cpu_reset, busy, error;

    always #5 clk = ~clk;

    hack_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    hack_loader #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .load_req  (load_req),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .error     (error)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Stream-level model: counts accepted bytes, derives words and the run/error outcome.
    int          m_bytes, m_n, m_words;
    bit          m_run, m_err, m_wr;
    logic [7:0]  m_lhi, m_hi;
    logic [AW-1:0] m_waddr;
    logic [15:0] m_wdata;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_bytes = 0; m_words = 0; m_n = 0;
            m_run = 0; m_err = 0; m_wr = 0;
        end else if (m_wr) begin
            m_wr = 0;
            if (m_words == m_n) m_run = 1;
        end else if (m_run || m_err) begin
            if (load_req) begin
                m_run = 0; m_err = 0; m_bytes = 0; m_words = 0;
            end
        end else if (bus.rx_valid) begin
            m_bytes++;
            if (m_bytes == 1) m_lhi = bus.rx_data;
            else if (m_bytes == 2) begin
                m_n = int'({m_lhi, bus.rx_data});
                if (m_n == 0) m_run = 1;
                else if (m_n > int'(MW)) m_err = 1;
            end else if (m_bytes % 2 == 1) m_hi = bus.rx_data;
            else begin
                m_waddr = AW'(m_words);
                m_wdata = {m_hi, bus.rx_data};
                m_words++;
                m_wr = 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] wlog[$];
    int          we_cyc = -1;
    int          fall_cyc = -1;
    logic        prev_cpu_reset = 1'b1;

    // Per-cycle comparison against the model, plus write log for literal checks.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_ready",  32'(bus.rx_ready), 32'(!m_run && !m_err && !m_wr));
            check("rom_we",    32'(bus.rom_we),   32'(m_wr));
            check("busy",      32'(busy),         32'(!m_run && !m_err));
            check("cpu_reset", 32'(cpu_reset),    32'(!m_run));
            check("error",     32'(error),        32'(m_err));
            if (m_wr) begin
                check("rom_addr",  32'(bus.rom_addr),  32'(m_waddr));
                check("rom_wdata", 32'(bus.rom_wdata), 32'(m_wdata));
            end
            if (bus.rom_we) begin
                wlog.push_back({16'(bus.rom_addr), bus.rom_wdata});
                we_cyc = cyc;
            end
            if (prev_cpu_reset && !cpu_reset) fall_cyc = cyc;
            prev_cpu_reset = cpu_reset;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit hs;
        int n;
        bus.rx_valid = 1'b0;
        tick(gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = bus.rx_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.rx_valid = 1'b0;
        if (!hs) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int gap);
        foreach (s[i]) send(s[i], (i == 0) ? 0 : gap);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload_busy",      32'(busy),      32'd1);
        check("reload_error",     32'(error),     32'd0);
        check("reload_rx_ready",  32'(bus.rx_ready), 32'd1);
    endtask

    task automatic check_basic(input string tag);
        check({tag, "_nwrites"}, 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check({tag, "_w0"}, wlog[0], 32'h0000_1234);
            check({tag, "_w1"}, wlog[1], 32'h0001_ABCD);
        end
        check({tag, "_release_latency"}, 32'(fall_cyc - we_cyc), 32'd1);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        chk_en = 1'b1;
        check("rst_cpu_reset", 32'(cpu_reset),     32'd1);
        check("rst_busy",      32'(busy),          32'd1);
        check("rst_rx_ready",  32'(bus.rx_ready),  32'd1);
        check("rst_rom_we",    32'(bus.rom_we),    32'd0);
        check("rst_error",     32'(error),         32'd0);
        check("rst_rom_addr",  32'(bus.rom_addr),  32'd0);
        check("rst_rom_wdata", 32'(bus.rom_wdata), 32'd0);

        // Basic two-word load.
        wlog.delete();
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 0);
        tick(2);
        check_basic("basic");

        // Reload from RUN.
        pulse_load();
        wlog.delete();
        send_stream('{8'h00, 8'h01, 8'h00, 8'h07}, 0);
        tick(2);
        check("reload_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) check("reload_w0", wlog[0], 32'h0000_0007);
        check("reload_run", 32'(cpu_reset), 32'd0);

        // Zero length header.
        pulse_load();
        wlog.delete();
        send_stream('{8'h00, 8'h00}, 0);
        check("zero_cpu_reset", 32'(cpu_reset), 32'd0);
        tick(3);
        check("zero_nwrites", 32'(wlog.size()), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);

        // Oversize header.
        pulse_load();
        wlog.delete();
        send_stream('{8'h80, 8'h01}, 0);
        tick(3);
        check("over_error",     32'(error),       32'd1);
        check("over_cpu_reset", 32'(cpu_reset),   32'd1);
        check("over_nwrites",   32'(wlog.size()), 32'd0);
        pulse_load();

        // Basic load with 3-cycle stalls between bytes.
        wlog.delete();
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 3);
        tick(2);
        check_basic("stall");

        // Reset in the middle of a load.
        pulse_load();
        wlog.delete();
        send_stream('{8'h00, 8'h02, 8'h12}, 0);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("midrst_rom_addr",  32'(bus.rom_addr),  32'd0);
        check("midrst_rom_wdata", 32'(bus.rom_wdata), 32'd0);
        check("midrst_busy",      32'(busy),          32'd1);
        tick(3);
        check("midrst_nwrites", 32'(wlog.size()), 32'd0);
        send_stream('{8'h00, 8'h01, 8'h55, 8'hAA}, 0);
        tick(2);
        check("midrst_nwrites2", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) check("midrst_w0", wlog[0], 32'h0000_55AA);
        check("midrst_run", 32'(cpu_reset), 32'd0);

        // Inclusive MAX_WORDS boundary, load_req held (and ignored) mid-load.
        pulse_load();
        wlog.delete();
        send_stream('{8'h00, 8'h04}, 0);
        load_req = 1'b1;
        send_stream('{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33}, 1);
        load_req = 1'b0;
        send_stream('{8'h44, 8'h44}, 1);
        tick(2);
        check("max_nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            check("max_w0", wlog[0], 32'h0000_1111);
            check("max_w3", wlog[3], 32'h0003_4444);
        end
        check("max_run", 32'(cpu_reset), 32'd0);
        check("max_addr_wrap", 32'(bus.rom_addr), 32'd0);

        // One past the boundary.
        pulse_load();
        send_stream('{8'h00, 8'h05}, 0);
        tick(2);
        check("max1_error", 32'(error), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
